// File: rtl/multi_box_drawer_if.sv
// ============================================================================
// Module      : multi_box_drawer_if
// Description : Box-attribute write port (valid/ready) for multi_box_drawer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_box_drawer_if #(
   parameter int NUM_BOXES = 4,
   parameter int COORD_W   = 10,
   parameter int COLOR_W   = 4
);
   localparam int c_idx_w = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;

   logic               wr_valid;
   logic               wr_ready;
   logic [c_idx_w-1:0] wr_index;
   logic               wr_enable;
   logic [COORD_W-1:0] wr_x;
   logic [COORD_W-1:0] wr_y;
   logic [COORD_W-1:0] wr_w;
   logic [COORD_W-1:0] wr_h;
   logic [COLOR_W-1:0] wr_red;
   logic [COLOR_W-1:0] wr_green;
   logic [COLOR_W-1:0] wr_blue;

   modport master (
      output wr_valid, wr_index, wr_enable, wr_x, wr_y, wr_w, wr_h,
             wr_red, wr_green, wr_blue,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_index, wr_enable, wr_x, wr_y, wr_w, wr_h,
             wr_red, wr_green, wr_blue,
      output wr_ready
   );
endinterface

`default_nettype wire

// File: rtl/multi_box_drawer.sv
// ============================================================================
// Module      : multi_box_drawer
// Description : Multi-box VGA pixel generator, shadow/active box registers,
//               two-stage hit test. Optional MULTI_BOX_COLLISION_EN adds
//               per-frame collision reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_box_drawer #(
   parameter int NUM_BOXES  = 4,
   parameter int COORD_W    = 10,
   parameter int COLOR_W    = 4,
   parameter int RES_WIDTH  = 640,
   parameter int RES_HEIGHT = 480
) (
   input  logic               clock,
   input  logic               reset_n,
   multi_box_drawer_if.slave  wr,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b
`ifdef MULTI_BOX_COLLISION_EN
   , output logic                 collision,
   output logic [NUM_BOXES-1:0]   collision_mask
`endif
);
   localparam int               c_idx_w = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
   localparam int               c_rgb_w = 3 * COLOR_W;
   localparam logic [COORD_W:0] c_res_w = (COORD_W + 1)'(RES_WIDTH);
   localparam logic [COORD_W:0] c_res_h = (COORD_W + 1)'(RES_HEIGHT);

   typedef struct packed {
      logic               enable;
      logic [COORD_W-1:0] bx;
      logic [COORD_W-1:0] by;
      logic [COORD_W-1:0] bw;
      logic [COORD_W-1:0] bh;
      logic [COLOR_W-1:0] red;
      logic [COLOR_W-1:0] green;
      logic [COLOR_W-1:0] blue;
   } box_t;

   box_t                 shadow_q [NUM_BOXES];
   box_t                 shadow_d [NUM_BOXES];
   box_t                 active_q [NUM_BOXES];
   box_t                 active_d [NUM_BOXES];
   logic [NUM_BOXES-1:0] hit_q, hit_d;
   logic                 in_res_q, in_res_d;
   logic [c_rgb_w-1:0]   rgb_q, rgb_d;

   logic                 w_wr_accept;
   box_t                 w_wr_box;
   logic [COORD_W:0]     w_x_end [NUM_BOXES];
   logic [COORD_W:0]     w_y_end [NUM_BOXES];
   logic [c_rgb_w-1:0]   w_sel;

   // A commit cycle never accepts a write, so shadow and active never race.
   assign wr.wr_ready = reset_n & ~frame_start;
   assign w_wr_accept = wr.wr_valid & wr.wr_ready;
   assign w_wr_box    = '{enable: wr.wr_enable, bx: wr.wr_x, by: wr.wr_y,
                          bw: wr.wr_w, bh: wr.wr_h, red: wr.wr_red,
                          green: wr.wr_green, blue: wr.wr_blue};

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (w_wr_accept) begin
         for (int i = 0; i < NUM_BOXES; i++) begin
            if (wr.wr_index == c_idx_w'(i)) begin
               shadow_d[i] = w_wr_box;
            end
         end
      end
      if (frame_start) begin
         active_d = shadow_q;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_box_end
         assign w_x_end[gi] = {1'b0, active_q[gi].bx} + {1'b0, active_q[gi].bw};
         assign w_y_end[gi] = {1'b0, active_q[gi].by} + {1'b0, active_q[gi].bh};
      end
   endgenerate

   // Stage 1: inclusive left/top, exclusive right/bottom edges, no wrap.
   always_comb begin
      hit_d = '0;
      for (int i = 0; i < NUM_BOXES; i++) begin
         hit_d[i] = active_q[i].enable
                  && (x >= active_q[i].bx) && ({1'b0, x} < w_x_end[i])
                  && (y >= active_q[i].by) && ({1'b0, y} < w_y_end[i]);
      end
      in_res_d = ({1'b0, x} < c_res_w) && ({1'b0, y} < c_res_h);
   end

   // Stage 2: lowest index wins, so scan from the top index downwards.
   always_comb begin
      w_sel = '0;
      for (int i = NUM_BOXES - 1; i >= 0; i--) begin
         if (hit_q[i]) begin
            w_sel = {active_q[i].red, active_q[i].green, active_q[i].blue};
         end
      end
      rgb_d = in_res_q ? w_sel : '0;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BOXES; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         hit_q    <= '0;
         in_res_q <= 1'b0;
         rgb_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         hit_q    <= hit_d;
         in_res_q <= in_res_d;
         rgb_q    <= rgb_d;
      end
   end

   assign r = rgb_q[c_rgb_w-1 -: COLOR_W];
   assign g = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign b = rgb_q[COLOR_W-1:0];

`ifdef MULTI_BOX_COLLISION_EN
   logic [NUM_BOXES-1:0] sticky_q, sticky_d;
   logic [NUM_BOXES-1:0] cmask_q, cmask_d;
   logic                 coll_q, coll_d;
   logic                 w_multi;
   logic [NUM_BOXES-1:0] w_new_hits;

   assign w_multi    = (hit_q & (hit_q - NUM_BOXES'(1))) != '0;
   assign w_new_hits = (in_res_q && w_multi) ? hit_q : '0;

   // Hits seen on the commit cycle seed the next frame's mask.
   always_comb begin
      sticky_d = sticky_q | w_new_hits;
      cmask_d  = cmask_q;
      coll_d   = coll_q;
      if (frame_start) begin
         cmask_d  = sticky_q;
         coll_d   = |sticky_q;
         sticky_d = w_new_hits;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sticky_q <= '0;
         cmask_q  <= '0;
         coll_q   <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         cmask_q  <= cmask_d;
         coll_q   <= coll_d;
      end
   end

   assign collision      = coll_q;
   assign collision_mask = cmask_q;
`endif
endmodule

`default_nettype wire
